// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with two bypassed read ports and a
// per-register pending-load scoreboard. Register 0 is hardwired to zero and
// never tracks loads.
//
// Load issue handshake: the issue is accepted on a rising edge when
// i_rf_ld_issue=1 and o_rf_sb_full=0. When o_rf_sb_full=1 the issue is
// dropped, and decode must hold i_rf_ld_issue/i_rf_ld_rdst until full drops.
module reg_file_sb #(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 32,
    parameter  int CNT_W = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    i_rf_raddr_a,
    input  logic [AW-1:0]    i_rf_raddr_b,
    output logic [WIDTH-1:0] o_rf_rdata_a,
    output logic [WIDTH-1:0] o_rf_rdata_b,
    output logic             o_rf_busy_a,
    output logic             o_rf_busy_b,
    input  logic [AW-1:0]    i_rf_waddr,
    input  logic             i_rf_we,
    input  logic [WIDTH-1:0] i_rf_wdata,
    input  logic             i_rf_wb_is_load,
    input  logic             i_rf_ld_issue,
    input  logic [AW-1:0]    i_rf_ld_rdst,
    input  logic             i_rf_ld_cancel,
    input  logic [AW-1:0]    i_rf_ld_cancel_rdst,
    output logic             o_rf_sb_full
);

    // Extended width so count + one increment never wraps before subtracting.
    localparam int EW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] regs     [NREGS];
    logic [CNT_W-1:0] cnt      [NREGS];
    logic [CNT_W-1:0] cnt_next [NREGS];
    logic [1:0]       dec_n    [NREGS];
    logic [EW-1:0]    sum_v    [NREGS];
    logic             inc_v    [NREGS];
    logic [NREGS-1:0] busy_vec;

    logic wr_en;
    assign wr_en = i_rf_we && (i_rf_waddr != '0);

    // Per-register decrement count, accepted increment and next counter value.
    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREGS; r++) begin
            dec_n[r] = {1'b0, (i_rf_we && i_rf_wb_is_load && (i_rf_waddr == AW'(r))
                               && (cnt[r] != '0))}
                     + {1'b0, (i_rf_ld_cancel && (i_rf_ld_cancel_rdst == AW'(r))
                               && (cnt[r] != '0))};
            // A saturated counter still accepts an issue if a slot frees this cycle.
            inc_v[r] = i_rf_ld_issue && (i_rf_ld_rdst == AW'(r))
                     && ((cnt[r] != CNT_MAX) || (dec_n[r] != 2'd0));
            sum_v[r] = EW'(cnt[r]) + EW'(inc_v[r]);
            if (r == 0) begin
                cnt_next[r] = '0;
            end else if (sum_v[r] > EW'(dec_n[r])) begin
                cnt_next[r] = CNT_W'(sum_v[r] - EW'(dec_n[r]));
            end else begin
                cnt_next[r] = '0;
            end
            // A load completing or cancelling this cycle already clears busy.
            busy_vec[r] = (r != 0) && (EW'(cnt[r]) > EW'(dec_n[r]));
        end
    end

    // Register storage: one-cycle write latency, register 0 never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (wr_en) begin
            regs[i_rf_waddr] <= i_rf_wdata;
        end
    end

    // Pending-load counters advance together every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Read ports with write-through bypass; all outputs forced to 0 in reset.
    always_comb begin
        o_rf_rdata_a = '0;
        o_rf_rdata_b = '0;
        o_rf_busy_a  = 1'b0;
        o_rf_busy_b  = 1'b0;
        o_rf_sb_full = 1'b0;
        if (rst) begin
            o_rf_rdata_a = (wr_en && (i_rf_waddr == i_rf_raddr_a)) ? i_rf_wdata
                                                                   : regs[i_rf_raddr_a];
            o_rf_rdata_b = (wr_en && (i_rf_waddr == i_rf_raddr_b)) ? i_rf_wdata
                                                                   : regs[i_rf_raddr_b];
            o_rf_busy_a  = busy_vec[i_rf_raddr_a];
            o_rf_busy_b  = busy_vec[i_rf_raddr_b];
            o_rf_sb_full = i_rf_ld_issue && (i_rf_ld_rdst != '0)
                         && (cnt[i_rf_ld_rdst] == CNT_MAX) && (dec_n[i_rf_ld_rdst] == 2'd0);
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scenarios plus randomized traffic checked against
// an array-based model of the register file and load scoreboard.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  raddr_a, raddr_b, waddr, ld_rdst, cancel_rdst;
    logic [31:0] rdata_a, rdata_b, wdata;
    logic        busy_a, busy_b, we, wb_is_load, ld_issue, ld_cancel, sb_full;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic [31:0] exp_q [$];

    reg_file_sb dut (
        .clk(clk), .rst(rst),
        .i_rf_raddr_a(raddr_a), .i_rf_raddr_b(raddr_b),
        .o_rf_rdata_a(rdata_a), .o_rf_rdata_b(rdata_b),
        .o_rf_busy_a(busy_a), .o_rf_busy_b(busy_b),
        .i_rf_waddr(waddr), .i_rf_we(we), .i_rf_wdata(wdata),
        .i_rf_wb_is_load(wb_is_load),
        .i_rf_ld_issue(ld_issue), .i_rf_ld_rdst(ld_rdst),
        .i_rf_ld_cancel(ld_cancel), .i_rf_ld_cancel_rdst(cancel_rdst),
        .o_rf_sb_full(sb_full)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
    endtask

    function automatic int dec_of(int a);
        int d;
        d = 0;
        if (we && wb_is_load && waddr == 5'(a) && m_cnt[a] > 0) d++;
        if (ld_cancel && cancel_rdst == 5'(a) && m_cnt[a] > 0) d++;
        return d;
    endfunction

    function automatic logic [31:0] exp_rdata(logic [4:0] a);
        if (!rst || a == 5'd0) return 32'h0;
        if (we && waddr == a) return wdata;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(logic [4:0] a);
        if (!rst || a == 5'd0) return 1'b0;
        return m_cnt[a] - dec_of(int'(a)) > 0;
    endfunction

    function automatic logic exp_full();
        if (!rst || !ld_issue || ld_rdst == 5'd0) return 1'b0;
        return m_cnt[ld_rdst] == 3 && dec_of(int'(ld_rdst)) == 0;
    endfunction

    // Apply the current inputs to the model as a rising edge would.
    task automatic model_tick();
        int nc [32];
        for (int r = 0; r < 32; r++) begin
            int d, n;
            d = dec_of(r);
            n = m_cnt[r] - d;
            if (r != 0 && ld_issue && ld_rdst == 5'(r) && (m_cnt[r] < 3 || d > 0)) n++;
            if (n < 0) n = 0;
            if (n > 3) n = 3;
            nc[r] = (r == 0) ? 0 : n;
        end
        for (int r = 0; r < 32; r++) m_cnt[r] = nc[r];
        if (we && waddr != 5'd0) m_reg[waddr] = wdata;
    endtask

    // ---------------- driver ----------------
    task automatic idle();
        raddr_a = '0; raddr_b = '0; waddr = '0; we = 0; wdata = '0;
        wb_is_load = 0; ld_issue = 0; ld_rdst = '0; ld_cancel = 0; cancel_rdst = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_tick();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst = 1'b0;
        model_reset();
        // Activity during reset must be invisible on the outputs.
        we = 1; waddr = 5'd5; wdata = 32'hFFFF_0000; raddr_a = 5'd5;
        ld_issue = 1; ld_rdst = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (rdata_a !== 32'h0 || sb_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_held rdata_a=%h sb_full=%b want 0/0", rdata_a, sb_full);
        end
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr_a = 5'(a);
            raddr_b = 5'(31 - a);
            #1;
            total++;
            if (rdata_a !== 32'h0 || rdata_b !== 32'h0 || busy_a !== 1'b0 ||
                busy_b !== 1'b0 || sb_full !== 1'b0) begin
                bad++;
                $display("FAIL reset_read addr=%0d rdata_a=%h rdata_b=%h busy=%b%b full=%b want all 0",
                         a, rdata_a, rdata_b, busy_a, busy_b, sb_full);
            end
        end
        cycle();
    endtask

    task automatic test_write_bypass();
        idle();
        we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_a = 5'd5;
        #1;
        total++;
        if (rdata_a !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL bypass got=%h want=deadbeef", rdata_a);
        end
        cycle();
        idle();
        raddr_a = 5'd5;
        #1;
        total++;
        if (rdata_a !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL stored got=%h want=deadbeef", rdata_a);
        end
        we = 1; waddr = 5'd0; wdata = 32'h1; raddr_b = 5'd0;
        #1;
        total++;
        if (rdata_b !== 32'h0) begin
            bad++;
            $display("FAIL r0_bypass got=%h want=0", rdata_b);
        end
        cycle();
        idle();
        raddr_b = 5'd0;
        #1;
        total++;
        if (rdata_b !== 32'h0) begin
            bad++;
            $display("FAIL r0_write got=%h want=0", rdata_b);
        end
    endtask

    task automatic test_load_busy();
        idle();
        ld_issue = 1; ld_rdst = 5'd7; raddr_a = 5'd7;
        #1;
        total++;
        if (busy_a !== 1'b0) begin
            bad++;
            $display("FAIL issue_same_cycle busy got=%b want=0", busy_a);
        end
        cycle();
        idle();
        raddr_a = 5'd7;
        #1;
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL issue_next_cycle busy got=%b want=1", busy_a);
        end
        we = 1; wb_is_load = 1; waddr = 5'd7; wdata = 32'h55;
        #1;
        total++;
        if (busy_a !== 1'b0 || rdata_a !== 32'h55) begin
            bad++;
            $display("FAIL load_complete busy=%b rdata=%h want 0/00000055", busy_a, rdata_a);
        end
        cycle();
        idle();
        raddr_a = 5'd7;
        #1;
        total++;
        if (busy_a !== 1'b0 || rdata_a !== 32'h55) begin
            bad++;
            $display("FAIL load_after busy=%b rdata=%h want 0/00000055", busy_a, rdata_a);
        end
    endtask

    task automatic test_full();
        idle();
        for (int i = 0; i < 3; i++) begin
            ld_issue = 1; ld_rdst = 5'd9;
            #1;
            total++;
            if (sb_full !== 1'b0) begin
                bad++;
                $display("FAIL fill_%0d full got=%b want=0", i, sb_full);
            end
            cycle();
        end
        ld_issue = 1; ld_rdst = 5'd9;
        #1;
        total++;
        if (sb_full !== 1'b1) begin
            bad++;
            $display("FAIL fourth_issue full got=%b want=1", sb_full);
        end
        cycle();
        // Issue together with a completion: accepted, count unchanged.
        we = 1; wb_is_load = 1; waddr = 5'd9; wdata = 32'h99;
        #1;
        total++;
        if (sb_full !== 1'b0) begin
            bad++;
            $display("FAIL issue_with_complete full got=%b want=0", sb_full);
        end
        cycle();
        idle();
        ld_issue = 1; ld_rdst = 5'd9;
        #1;
        total++;
        if (sb_full !== 1'b1) begin
            bad++;
            $display("FAIL still_three full got=%b want=1", sb_full);
        end
        idle();
        // Drain with cancels; busy must track the remaining count.
        for (int i = 0; i < 3; i++) begin
            ld_cancel = 1; cancel_rdst = 5'd9;
            cycle();
            idle();
            raddr_b = 5'd9;
            #1;
            total++;
            if (busy_b !== (i < 2)) begin
                bad++;
                $display("FAIL drain_%0d busy got=%b want=%b", i, busy_b, (i < 2));
            end
        end
    endtask

    task automatic test_cancel();
        idle();
        ld_issue = 1; ld_rdst = 5'd4;
        cycle();
        idle();
        ld_cancel = 1; cancel_rdst = 5'd4;
        cycle();
        idle();
        raddr_a = 5'd4;
        #1;
        total++;
        if (busy_a !== 1'b0) begin
            bad++;
            $display("FAIL cancel busy got=%b want=0", busy_a);
        end
        ld_cancel = 1; cancel_rdst = 5'd4;
        cycle();
        idle();
        ld_issue = 1; ld_rdst = 5'd4;
        cycle();
        idle();
        raddr_a = 5'd4;
        #1;
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL cancel_underflow busy got=%b want=1", busy_a);
        end
        we = 1; wb_is_load = 0; waddr = 5'd4; wdata = 32'hA1A1;
        #1;
        total++;
        if (busy_a !== 1'b1 || rdata_a !== 32'hA1A1) begin
            bad++;
            $display("FAIL alu_wb busy=%b rdata=%h want 1/0000a1a1", busy_a, rdata_a);
        end
        cycle();
        idle();
        raddr_a = 5'd4;
        #1;
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL alu_wb_after busy got=%b want=1", busy_a);
        end
        ld_cancel = 1; cancel_rdst = 5'd4;
        cycle();
        idle();
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int i = 0; i < 400; i++) begin
            raddr_a     = 5'($urandom_range(0, 7));
            raddr_b     = 5'($urandom_range(0, 7));
            we          = 1'($urandom_range(0, 1));
            waddr       = 5'($urandom_range(0, 7));
            wdata       = $urandom;
            wb_is_load  = 1'($urandom_range(0, 1));
            ld_issue    = ($urandom_range(0, 9) < 6);
            ld_rdst     = 5'($urandom_range(0, 7));
            ld_cancel   = ($urandom_range(0, 9) < 2);
            cancel_rdst = 5'($urandom_range(0, 7));
            #1;
            exp_q.push_back(exp_rdata(raddr_a));
            exp_q.push_back(exp_rdata(raddr_b));
            e = exp_q.pop_front();
            total++;
            if (rdata_a !== e) begin
                bad++;
                $display("FAIL rand_rdata_a i=%0d got=%h want=%h", i, rdata_a, e);
            end
            e = exp_q.pop_front();
            total++;
            if (rdata_b !== e) begin
                bad++;
                $display("FAIL rand_rdata_b i=%0d got=%h want=%h", i, rdata_b, e);
            end
            total++;
            if (busy_a !== exp_busy(raddr_a) || busy_b !== exp_busy(raddr_b)) begin
                bad++;
                $display("FAIL rand_busy i=%0d got=%b%b want=%b%b", i, busy_a, busy_b,
                         exp_busy(raddr_a), exp_busy(raddr_b));
            end
            total++;
            if (sb_full !== exp_full()) begin
                bad++;
                $display("FAIL rand_full i=%0d got=%b want=%b", i, sb_full, exp_full());
            end
            cycle();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        we = 1; waddr = 5'd3; wdata = 32'h1234;
        cycle();
        idle();
        ld_issue = 1; ld_rdst = 5'd3;
        cycle();
        cycle();
        idle();
        raddr_a = 5'd3;
        #1;
        total++;
        if (rdata_a !== 32'h1234 || busy_a !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset rdata=%h busy=%b want 00001234/1", rdata_a, busy_a);
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (rdata_a !== 32'h0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL async_reset rdata=%h busy=%b want 0/0", rdata_a, busy_a);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (rdata_a !== 32'h0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL post_reset rdata=%h busy=%b want 0/0", rdata_a, busy_a);
        end
        cycle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        model_reset();
        test_reset();
        test_write_bypass();
        test_load_busy();
        test_full();
        test_cancel();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
